push_debounce: RTL and testbench
================================

// Module: push_debounce
// PURPOSE
//  Cleans the raw push-button input before it reaches the push counter. Synchronises
//  the button to clk, rejects bounce/glitches, emits single-cycle press, release and
//  step pulses, and generates auto-repeat steps while the button is held.
//  pus_step drives the counter's increment.
// PARAMETERS
//  DEBOUNCE_CYC    1_000_000   cycles input must be stable to accept a change (20 ms @ 50 MHz); >=2
//  REPEAT_DLY_CYC  25_000_000  held cycles after accepted press before first repeat step (0.5 s)
//  REPEAT_CYC      5_000_000   cycles between subsequent repeat steps (0.1 s); >=2
//  CNT_W           25          timer width; must hold max(all *_CYC)-1
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst_n        in   1      asynchronous reset, active-low
//  pus          in   1      raw button, asynchronous, 1 = pressed
//  en_repeat    in   1      1 = auto-repeat enabled while held
//  pus_level    out  1      debounced button level
//  pus_press    out  1      1-cycle pulse on accepted press
//  pus_release  out  1      1-cycle pulse on accepted release
//  pus_step     out  1      1-cycle pulse on accepted press and on each repeat
// BEHAVIOUR
//  - Reset (rst_n=0, async): sync FFs=0, state=IDLE, timer=0, all outputs 0.
//  - 2-FF synchroniser s1<=pus, s2<=s1; FSM uses s2 only.
//  - All outputs are registered; pulses last exactly one clk cycle.
//  - One shared timer cnt (CNT_W bits), cleared on every state change.
//  - IDLE: level=0. s2=1 -> DB_PRESS.
//  - DB_PRESS: s2=0 -> IDLE (glitch dropped, no pulse). Else cnt++.
//    cnt==DEBOUNCE_CYC-1 -> HELD; assert press+step; level<=1.
//  - HELD: s2=0 -> DB_REL. Else if en_repeat: cnt++.
//    cnt==REPEAT_DLY_CYC-1 -> REPEAT, assert step.
//    en_repeat=0 holds cnt at 0.
//  - REPEAT: s2=0 -> DB_REL. en_repeat=0 -> HELD, no pulse. Else cnt++.
//    cnt==REPEAT_CYC-1 -> assert step; cnt<=0; stay.
//  - DB_REL: level stays 1. s2=1 -> HELD (bounce; no pulse; repeat delay restarts).
//    Else cnt++; cnt==DEBOUNCE_CYC-1 -> IDLE, assert release, level<=0.
//  - Latency: pus rises before edge k and stays high.
//    press/step are high for the cycle after edge k+2+DEBOUNCE_CYC.
//    level rises at that same edge. Release has the same latency from the pus fall.
//  - press and release are never high together. step is never high in IDLE/DB_*.
//  - Timer never wraps: every compare-hit clears or leaves the state.
//  - Async reset mid-press: outputs drop immediately. After release, a held button
//    re-qualifies as a new press: full debounce, then press pulse.
// TESTING (sim params DEBOUNCE_CYC=4, REPEAT_DLY_CYC=10, REPEAT_CYC=3)
//  1. pus 0->1 held at edge 0, en_repeat=0 -> press & step high in cycle after edge 6.
//     level=1 from edge 6. No further step.
//  2. pus high 3 cycles then low (glitch) -> no press/step/level change ever.
//  3. Held press, then pus bounces 1-0-1-0 with <4-cycle gaps, then low.
//     -> exactly one release, 4+2 cycles after the final fall. No extra press.
//  4. en_repeat=1, hold 40 cycles after press.
//     -> first repeat step 10 cycles after press pulse, then every 3 cycles. Count = 1+ repeats.
//  5. REPEAT state, en_repeat drops -> no further steps. Release still yields one release pulse.
//  6. rst_n low mid-HELD -> all outputs 0 asynchronously.
//     rst_n high with pus held -> press re-issued 6 cycles later.

Source files
------------

// File: rtl/push_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, and single-cycle
// press/release/step pulses, with auto-repeat steps while the button is held.
module push_debounce #(
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int REPEAT_DLY_CYC = 25_000_000,
    parameter int REPEAT_CYC     = 5_000_000,
    parameter int CNT_W          = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pus,
    input  logic en_repeat,
    output logic pus_level,
    output logic pus_press,
    output logic pus_release,
    output logic pus_step
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY_CYC - 1);
    localparam logic [CNT_W-1:0] RC_LAST  = CNT_W'(REPEAT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        HELD     = 3'd2,
        REPEAT   = 3'd3,
        DB_REL   = 3'd4
    } state_t;

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= pus;
            r_s2 <= r_s1;
        end
    end

    // One shared timer; every state change clears it, so a compare hit never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_step    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_step    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_level <= 1'b0;
                    if (r_s2) begin
                        r_state <= DB_PRESS;
                        r_cnt   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!r_s2) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                        r_step  <= 1'b1;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!r_s2) begin
                        r_state <= DB_REL;
                        r_cnt   <= '0;
                    end else if (!en_repeat) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DLY_LAST) begin
                        r_state <= REPEAT;
                        r_cnt   <= '0;
                        r_step  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!r_s2) begin
                        r_state <= DB_REL;
                        r_cnt   <= '0;
                    end else if (!en_repeat) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == RC_LAST) begin
                        r_cnt  <= '0;
                        r_step <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DB_REL: begin
                    // A bounce back high returns to HELD, which restarts the repeat delay.
                    if (r_s2) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_release <= 1'b1;
                        r_level   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pus_level   = r_level;
    assign pus_press   = r_press;
    assign pus_release = r_release;
    assign pus_step    = r_step;

endmodule

// File: tb/tb_push_debounce.sv
// Randomised bench for push_debounce: a run-length reference model predicts output
// events into a scoreboard queue that an independent monitor drains.
module tb_push_debounce;
    localparam int DB  = 4;
    localparam int DLY = 10;
    localparam int RC  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pus = 1'b0;
    logic en_repeat = 1'b0;
    logic pus_level, pus_press, pus_release, pus_step;

    push_debounce #(
        .DEBOUNCE_CYC(DB), .REPEAT_DLY_CYC(DLY), .REPEAT_CYC(RC), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pus(pus), .en_repeat(en_repeat),
        .pus_level(pus_level), .pus_press(pus_press),
        .pus_release(pus_release), .pus_step(pus_step)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   eg;
        logic prs;
        logic rls;
        logic stp;
        logic lvl;
    } ev_t;

    ev_t sbq[$];
    int  errors = 0;
    int  checks = 0;
    int  edge_no = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Reference: a change is accepted after DB+1 consecutive synchronised samples
    // differing from the level; repeat steps count consecutive held+enabled edges.
    logic m_s1, m_s2, m_prev, m_lvl;
    int   m_dev, m_rep;

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0; m_lvl = 1'b0;
        m_dev = 0; m_rep = 0;
    endtask

    task automatic model_edge();
        logic s, p_o, r_o, s_o, old;
        int   eg;
        eg = edge_no + 1;
        p_o = 1'b0; r_o = 1'b0; s_o = 1'b0; old = m_lvl;
        s = m_s2; m_s2 = m_s1; m_s1 = pus;
        if (s != m_lvl) begin
            m_dev++;
            m_rep = 0;
            if (m_dev == DB + 1) begin
                m_lvl = s; m_dev = 0;
                p_o = s; s_o = s; r_o = !s;
            end
        end else begin
            m_dev = 0;
            if (m_lvl && en_repeat && m_prev) begin
                m_rep++;
                if (m_rep == DLY || (m_rep > DLY && (m_rep - DLY) % RC == 0)) s_o = 1'b1;
            end else begin
                m_rep = 0;
            end
        end
        m_prev = s;
        if (p_o || r_o || s_o || (m_lvl != old))
            sbq.push_back('{eg, p_o, r_o, s_o, m_lvl});
    endtask

    task automatic cyc(input logic p, input logic e);
        @(negedge clk);
        pus = p; en_repeat = e;
        model_edge();
    endtask

    task automatic run(input logic p, input logic e, input int n);
        for (int i = 0; i < n; i++) cyc(p, e);
    endtask

    task automatic check_zero(input string name);
        logic [3:0] got;
        got = {pus_level, pus_press, pus_release, pus_step};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL %s: outputs l/p/r/s=%b, expected 0000", name, got);
        end
    endtask

    task automatic reset_mid(input logic p);
        @(negedge clk);
        rst_n = 1'b0; pus = p;
        #1;
        check_zero("async_reset");
        if (m_lvl) sbq.push_back('{edge_no + 1, 1'b0, 1'b0, 1'b0, 1'b0});
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_edge();
    endtask

    initial begin : monitor
        logic prev_lvl;
        ev_t  ex;
        prev_lvl = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pus_press || pus_release || pus_step || (pus_level !== prev_lvl)) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: edge %0d l/p/r/s=%b%b%b%b, expected no event",
                             edge_no, pus_level, pus_press, pus_release, pus_step);
                end else begin
                    ex = sbq.pop_front();
                    if (ex.eg != edge_no || ex.prs !== pus_press || ex.rls !== pus_release ||
                        ex.stp !== pus_step || ex.lvl !== pus_level) begin
                        errors++;
                        $display("FAIL sb_event: edge %0d l/p/r/s=%b%b%b%b, expected edge %0d l/p/r/s=%b%b%b%b",
                                 edge_no, pus_level, pus_press, pus_release, pus_step,
                                 ex.eg, ex.lvl, ex.prs, ex.rls, ex.stp);
                    end
                end
            end
            prev_lvl = pus_level;
        end
    end

    initial begin : stim
        logic p, e;
        int   len;
        model_reset();
        #2;
        check_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_edge();
        run(0, 0, 4);
        // held press, no repeat
        run(1, 0, 20);  run(0, 0, 12);
        // short glitch
        run(1, 0, 3);   run(0, 0, 12);
        // release bounce
        run(1, 0, 10);  run(0, 0, 2); run(1, 0, 1); run(0, 0, 3); run(1, 0, 2); run(0, 0, 15);
        // auto-repeat
        run(1, 1, 46);  run(0, 1, 12);
        // repeat disabled mid-repeat
        run(1, 1, 25);  run(1, 0, 10); run(0, 0, 12);
        // reset while held, button kept down
        run(1, 0, 12);  reset_mid(1'b1); run(1, 0, 12); run(0, 0, 12);
        // random bursts
        e = 1'b0;
        for (int b = 0; b < 300; b++) begin
            p = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) e = ~e;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 40) : $urandom_range(1, 6);
            run(p, e, len);
            if ($urandom_range(0, 59) == 0) reset_mid(p);
        end
        run(0, 0, 15);
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d events outstanding, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
